// File: rtl/delay_meas_pkg.sv
// Shared types and constants for the delay-measurement sequencer.
//   state_t  : sequencer state encoding (3 bits)
//   CNT_W    : width of the external program/measure counter
//   CNT_ZERO : value loaded into the counter at the start of each sample
package delay_meas_pkg;

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_ZERO = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_WAIT = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Subtraction that floors at zero instead of wrapping.
    function automatic logic [CNT_W-1:0] sub_sat0(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W-1:0] b);
        return (a > b) ? (a - b) : CNT_ZERO;
    endfunction

endpackage

// File: rtl/echo_sync_edge.sv
// Two-flop synchronizer for the asynchronous echo return, plus a delay flop
// for rising-edge detection.
//   clk, rst_n : clock, synchronous active-low reset
//   echo       : asynchronous input
//   echo_lvl   : synchronized level
//   echo_rise  : one-cycle pulse on a synchronized 0->1 transition
module echo_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic echo,
    output logic echo_lvl,
    output logic echo_rise
);

    logic sync1;
    logic sync2;
    logic sync3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= echo;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign echo_lvl  = sync2;
    assign echo_rise = sync2 & ~sync3;

endmodule

// File: rtl/delay_meas_ctrl.sv
// Sequencer for the 8-bit program/measure counter: fires a launch pulse,
// clears and runs the counter, stops it on the first synchronized echo rise,
// averages 2**NSAMP_LOG2 samples or aborts when the counter reaches TIMEOUT.
//   clk, rst_n : clock, synchronous active-low reset
//   ena        : design enable, low forces IDLE
//   start      : run request, sampled in IDLE only
//   echo       : asynchronous return signal
//   cnt_q      : current counter value
//   cnt_load   : counter load strobe;  cnt_ld_val : load value (constant zero)
//   cnt_en     : counter enable (drops in the same cycle as the echo edge)
//   launch     : one-cycle launch pulse per sample
//   busy       : run in progress
//   valid      : result valid (level);  timeout : last run aborted (level)
//   result     : averaged delay in clk cycles
module delay_meas_ctrl
    import delay_meas_pkg::*;
#(
    parameter int unsigned NSAMP_LOG2 = 2,
    parameter int unsigned OFFSET     = 1,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned GAP_CYC    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             echo,
    input  logic [CNT_W-1:0] cnt_q,
    output logic             cnt_load,
    output logic [CNT_W-1:0] cnt_ld_val,
    output logic             cnt_en,
    output logic             launch,
    output logic             busy,
    output logic             valid,
    output logic             timeout,
    output logic [CNT_W-1:0] result
);

    localparam int unsigned ACC_W = CNT_W + NSAMP_LOG2;
    localparam int unsigned SC_W  = (NSAMP_LOG2 > 0) ? NSAMP_LOG2 : 1;
    localparam int unsigned GAP_W = 4;

    localparam logic [SC_W-1:0]  SC_LAST   = SC_W'((1 << NSAMP_LOG2) - 1);
    localparam logic [CNT_W-1:0] OFFSET_V  = CNT_W'(OFFSET);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [GAP_W-1:0] GAP_V     = GAP_W'(GAP_CYC);

    state_t            state;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_next;
    logic [SC_W-1:0]   sample_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              to_hit;
    logic              echo_lvl;
    logic              echo_rise;
    logic [CNT_W-1:0]  avg;

    echo_sync_edge u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .echo      (echo),
        .echo_lvl  (echo_lvl),
        .echo_rise (echo_rise)
    );

    assign cnt_ld_val = CNT_ZERO;

    // Stop the counter in the very cycle the edge is seen so it freezes on the capture.
    assign cnt_en = (state == ST_WAIT) & ~echo_rise;

    assign acc_next = acc + ACC_W'(sub_sat0(cnt_q, OFFSET_V));
    assign avg      = CNT_W'(acc >> NSAMP_LOG2);

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            acc        <= '0;
            sample_cnt <= '0;
            gap_cnt    <= '0;
            to_hit     <= 1'b0;
            cnt_load   <= 1'b0;
            launch     <= 1'b0;
            busy       <= 1'b0;
            valid      <= 1'b0;
            timeout    <= 1'b0;
            result     <= CNT_ZERO;
        end else if (!ena) begin
            state    <= ST_IDLE;
            cnt_load <= 1'b0;
            launch   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_LOAD;
                        cnt_load   <= 1'b1;
                        launch     <= 1'b1;
                        busy       <= 1'b1;
                        valid      <= 1'b0;
                        timeout    <= 1'b0;
                        to_hit     <= 1'b0;
                        acc        <= '0;
                        sample_cnt <= '0;
                    end
                end
                ST_LOAD: begin
                    cnt_load <= 1'b0;
                    launch   <= 1'b0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // An edge wins over a simultaneous timeout.
                    if (echo_rise) begin
                        acc <= acc_next;
                        if (sample_cnt == SC_LAST) begin
                            state <= ST_DONE;
                        end else begin
                            sample_cnt <= sample_cnt + SC_W'(1);
                            gap_cnt    <= '0;
                            state      <= ST_GAP;
                        end
                    end else if (cnt_q == TIMEOUT_V) begin
                        to_hit <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt != '1) begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                    // Echo must have returned low so the next sample sees a fresh edge.
                    if ((gap_cnt >= GAP_V) && !echo_lvl) begin
                        state    <= ST_LOAD;
                        cnt_load <= 1'b1;
                        launch   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    valid   <= 1'b1;
                    timeout <= to_hit;
                    result  <= to_hit ? 8'hFF : avg;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_meas_ctrl.sv
// Self-checking bench for delay_meas_ctrl: a single-sample instance and a
// four-sample instance, each next to a behavioural model of the 8-bit counter.
module tb_delay_meas_ctrl;
    import delay_meas_pkg::*;

    localparam int unsigned OFFSET  = 1;
    localparam int unsigned GAP_CYC = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, ena, start, echo, sel;
    logic start0, start1;
    logic [7:0] cnt_q0, cnt_q1, ld_val0, ld_val1, result0, result1;
    logic cnt_load0, cnt_load1, cnt_en0, cnt_en1, launch0, launch1;
    logic busy0, busy1, valid0, valid1, timeout0, timeout1;

    assign start0 = start & ~sel;
    assign start1 = start & sel;

    delay_meas_ctrl #(.NSAMP_LOG2(0), .OFFSET(OFFSET), .TIMEOUT(255), .GAP_CYC(GAP_CYC)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start0), .echo(echo), .cnt_q(cnt_q0),
        .cnt_load(cnt_load0), .cnt_ld_val(ld_val0), .cnt_en(cnt_en0), .launch(launch0),
        .busy(busy0), .valid(valid0), .timeout(timeout0), .result(result0)
    );

    delay_meas_ctrl #(.NSAMP_LOG2(2), .OFFSET(OFFSET), .TIMEOUT(255), .GAP_CYC(GAP_CYC)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start1), .echo(echo), .cnt_q(cnt_q1),
        .cnt_load(cnt_load1), .cnt_ld_val(ld_val1), .cnt_en(cnt_en1), .launch(launch1),
        .busy(busy1), .valid(valid1), .timeout(timeout1), .result(result1)
    );

    // Behavioural counters standing in for Contador8b.
    always @(posedge clk) begin
        if (!rst_n)          cnt_q0 <= 8'h00;
        else if (cnt_load0)  cnt_q0 <= ld_val0;
        else if (cnt_en0)    cnt_q0 <= cnt_q0 + 8'd1;
    end
    always @(posedge clk) begin
        if (!rst_n)          cnt_q1 <= 8'h00;
        else if (cnt_load1)  cnt_q1 <= ld_val1;
        else if (cnt_en1)    cnt_q1 <= cnt_q1 + 8'd1;
    end

    logic       launch_o, busy_o, valid_o, timeout_o, cnt_en_o, cnt_load_o;
    logic [7:0] result_o, ld_val_o;
    assign launch_o   = sel ? launch1   : launch0;
    assign busy_o     = sel ? busy1     : busy0;
    assign valid_o    = sel ? valid1    : valid0;
    assign timeout_o  = sel ? timeout1  : timeout0;
    assign cnt_en_o   = sel ? cnt_en1   : cnt_en0;
    assign cnt_load_o = sel ? cnt_load1 : cnt_load0;
    assign result_o   = sel ? result1   : result0;
    assign ld_val_o   = sel ? ld_val1   : ld_val0;

    int cyc = 0;
    int n_launch = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (launch_o) n_launch <= n_launch + 1;

    int n_checks = 0;
    int n_errors = 0;
    int last_res0 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: each echo arriving k cycles after launch is captured as k+1,
    // reduced by OFFSET (floored at 0); the run reports the truncated mean.
    function automatic int ref_avg(input int ks[$], input int log2n);
        int sum = 0;
        foreach (ks[i]) begin
            int raw = ks[i] + 1;
            sum += (raw > int'(OFFSET)) ? raw - int'(OFFSET) : 0;
        end
        return sum >> log2n;
    endfunction

    task automatic wait_launch(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (launch_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            if (!busy_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One complete run; echo for sample i rises ks[i] cycles after its launch.
    task automatic run(input logic s, input int ks[$], input bit poke);
        int  exp;
        int  nl0;
        int  prev_l;
        bit  ok;
        sel    = s;
        exp    = ref_avg(ks, s ? 2 : 0);
        nl0    = n_launch;
        prev_l = 0;
        @(posedge clk); #1;
        start = 1'b1;
        foreach (ks[i]) begin
            wait_launch(ok);
            check("launch_seen", 32'(ok), 32'd1);
            if (i > 0) check("launch_gap", 32'((cyc - prev_l) >= int'(GAP_CYC + 2)), 32'd1);
            prev_l = cyc;
            @(posedge clk); #1;
            check("launch_width", 32'(launch_o), 32'd0);
            if (poke && i == 1) start = 1'b1;
            for (int c = 1; c < ks[i]; c++) begin
                @(posedge clk); #1;
                start = 1'b0;
            end
            start = 1'b0;
            echo  = 1'b1;
            repeat (3) begin @(posedge clk); #1; end
            echo = 1'b0;
        end
        wait_idle(ok);
        check("run_done", 32'(ok), 32'd1);
        check("valid", 32'(valid_o), 32'd1);
        check("timeout", 32'(timeout_o), 32'd0);
        check("result", 32'(result_o), 32'(exp));
        check("launch_count", 32'(n_launch - nl0), 32'(ks.size()));
        if (!s) last_res0 = exp;
    endtask

    task automatic run_timeout(input logic s);
        bit ok;
        sel  = s;
        echo = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        wait_launch(ok);
        check("to_launch_seen", 32'(ok), 32'd1);
        wait_idle(ok);
        check("to_done", 32'(ok), 32'd1);
        check("to_valid", 32'(valid_o), 32'd1);
        check("to_flag", 32'(timeout_o), 32'd1);
        check("to_result", 32'(result_o), 32'hFF);
        check("to_busy", 32'(busy_o), 32'd0);
        if (!s) last_res0 = 255;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int  kq[$];
        bit  ok;
        rst_n = 1'b0;
        ena   = 1'b1;
        start = 1'b1;
        echo  = 1'b1;
        sel   = 1'b0;

        // Reset with start and echo asserted.
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_timeout", 32'(timeout_o), 32'd0);
        check("rst_result", 32'(result_o), 32'd0);
        check("rst_launch", 32'(launch_o), 32'd0);
        check("rst_cnt_load", 32'(cnt_load_o), 32'd0);
        check("rst_cnt_en", 32'(cnt_en_o), 32'd0);
        check("rst_ld_val", 32'(ld_val_o), 32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        start = 1'b0;
        echo  = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_busy", 32'(busy_o), 32'd0);
        check("post_rst_cnt_en", 32'(cnt_en_o), 32'd0);

        // Single sample, k=10.
        kq = {10};
        run(1'b0, kq, 1'b0);

        // Four-sample average with a stray start while busy.
        kq = {10, 11, 12, 14};
        run(1'b1, kq, 1'b1);

        // Minimum delay.
        kq = {1};
        run(1'b0, kq, 1'b0);

        // Echo edge in the same cycle the counter hits TIMEOUT.
        kq = {254};
        run(1'b0, kq, 1'b0);

        run_timeout(1'b0);
        run_timeout(1'b1);

        // Abort mid-WAIT.
        sel = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        wait_launch(ok);
        check("abort_launch_seen", 32'(ok), 32'd1);
        repeat (3) begin @(posedge clk); #1; end
        ena = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_cnt_en", 32'(cnt_en_o), 32'd0);
        check("abort_result_held", 32'(result_o), 32'(last_res0));
        ena = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        check("abort_idle", 32'(busy_o), 32'd0);
        kq = {7};
        run(1'b0, kq, 1'b0);

        // Randomized runs on both instances.
        for (int r = 0; r < 4; r++) begin
            kq = {};
            for (int j = 0; j < 4; j++) kq.push_back(int'($urandom_range(40, 2)));
            run(1'b1, kq, r[0]);
            kq = {int'($urandom_range(200, 1))};
            run(1'b0, kq, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
